// File: rtl/parity_pkg.sv
// Parity definitions shared by the UART RX checker and the TX parity generator.
// The helper takes a wide zero-extended word, because zero bits never change an XOR reduction.
package parity_pkg;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Widest data word the shared helper accepts.
    localparam int PARITY_MAX_WIDTH = 64;

    typedef logic parity_type_t;

    // The parity bit that completes the frame under the requested parity.
    // With odd parity the bit is inverted, so the total count of ones becomes odd.
    function automatic logic expected_parity(
        input logic [PARITY_MAX_WIDTH-1:0] data,
        input parity_type_t                ptype
    );
        return (^data) ^ ptype;
    endfunction

endpackage

// File: rtl/parity_rx_if.sv
// Frame bus between the RX deserializer, the parity checker and the status/FIFO side.
// The master drives the received frame; the slave (parity_rx) returns the checked frame and status.
interface parity_rx_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
);
    import parity_pkg::*;

    logic                     valid_in;
    logic [DATA_WIDTH-1:0]    data_in;
    logic                     received_parity;
    parity_type_t             parity_type;
    logic                     err_clear;

    logic                     valid_out;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     parity_error;
    logic                     err_sticky;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    modport master (
        output valid_in, data_in, received_parity, parity_type, err_clear,
        input  valid_out, data_out, parity_error, err_sticky, err_count
    );

    modport slave (
        input  valid_in, data_in, received_parity, parity_type, err_clear,
        output valid_out, data_out, parity_error, err_sticky, err_count
    );

endinterface

// File: rtl/parity_calc.sv
// Purely combinational expected-parity calculation for one data word.
// It zero-extends the word so the shared package function can be used at any width up to its limit.
module parity_calc
    import parity_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  parity_type_t          parity_type_i,
    output logic                  expected_o
);

    logic [PARITY_MAX_WIDTH-1:0] dataWide;

    always_comb begin
        dataWide                   = '0;
        dataWide[DATA_WIDTH-1:0]   = data_i;
        expected_o                 = expected_parity(dataWide, parity_type_i);
    end

endmodule

// File: rtl/parity_rx.sv
// Receive-side parity checker: registers each frame with its mismatch flag and
// keeps a sticky error flag plus a saturating error count for status reporting.
module parity_rx
    import parity_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    parity_rx_if.slave  bus
);

    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};

    logic                     expectedParity;
    logic                     mismatch;

    logic                     valid_q,  valid_d;
    logic [DATA_WIDTH-1:0]    data_q,   data_d;
    logic                     perr_q,   perr_d;
    logic                     sticky_q, sticky_d;
    logic [ERR_CNT_WIDTH-1:0] count_q,  count_d;

    logic                     stickyBase;
    logic [ERR_CNT_WIDTH-1:0] countBase;

    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_calc (
        .data_i        (bus.data_in),
        .parity_type_i (bus.parity_type),
        .expected_o    (expectedParity)
    );

    assign mismatch = bus.received_parity ^ expectedParity;

    // A clear on the same edge as a bad frame is applied first, so that frame still counts.
    always_comb begin
        valid_d    = bus.valid_in;
        data_d     = data_q;
        perr_d     = perr_q;
        stickyBase = bus.err_clear ? 1'b0 : sticky_q;
        countBase  = bus.err_clear ? '0   : count_q;
        sticky_d   = stickyBase;
        count_d    = countBase;

        if (bus.valid_in) begin
            data_d = bus.data_in;
            perr_d = mismatch;
            if (mismatch) begin
                sticky_d = 1'b1;
                count_d  = (countBase == CNT_MAX) ? countBase : countBase + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            perr_q   <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            perr_q   <= perr_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign bus.valid_out    = valid_q;
    assign bus.data_out     = data_q;
    assign bus.parity_error = perr_q;
    assign bus.err_sticky   = sticky_q;
    assign bus.err_count    = count_q;

endmodule

// File: tb/tb_parity_rx.sv
// Bench for parity_rx: directed frames, counter saturation, async reset and a
// randomized stream, all checked against a ones-counting reference model.
module tb_parity_rx;
    import parity_pkg::*;

    localparam int DW      = 8;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    parity_rx_if #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) bus();

    parity_rx #(
        .DATA_WIDTH    (DW),
        .ERR_CNT_WIDTH (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] expData;
    logic          expPerr;
    logic          expValid;
    logic          expSticky;
    int            expCount;

    // Frame is wrong when data ones plus the parity bit do not have the parity the type asks for.
    function automatic logic isMismatch(logic [DW-1:0] d, logic rp, logic pt);
        int total;
        total = $countones(d) + int'(rp);
        return ((total % 2) != int'(pt));
    endfunction

    function automatic logic parityFor(logic [DW-1:0] d, logic pt, logic bad);
        int r;
        r = (($countones(d) % 2) == int'(pt)) ? 0 : 1;
        if (bad) r = 1 - r;
        return (r != 0);
    endfunction

    task automatic checkBit(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkBit({tag, ".valid_out"},    32'(bus.valid_out),    32'(expValid));
        checkBit({tag, ".data_out"},     32'(bus.data_out),     32'(expData));
        checkBit({tag, ".parity_error"}, 32'(bus.parity_error), 32'(expPerr));
        checkBit({tag, ".err_sticky"},   32'(bus.err_sticky),   32'(expSticky));
        checkBit({tag, ".err_count"},    32'(bus.err_count),    32'(expCount));
    endtask

    task automatic modelReset();
        expData   = '0;
        expPerr   = 1'b0;
        expValid  = 1'b0;
        expSticky = 1'b0;
        expCount  = 0;
    endtask

    task automatic applyStimulus(input string tag, input logic v, input logic [DW-1:0] d,
                                 input logic rp, input logic pt, input logic clr);
        bool_drive: begin
            bus.valid_in        = v;
            bus.data_in         = d;
            bus.received_parity = rp;
            bus.parity_type     = pt;
            bus.err_clear       = clr;
        end
        @(posedge clk);
        if (rst_n) begin
            if (clr) begin
                expSticky = 1'b0;
                expCount  = 0;
            end
            expValid = v;
            if (v) begin
                expData = d;
                expPerr = isMismatch(d, rp, pt);
                if (expPerr) begin
                    expSticky = 1'b1;
                    if (expCount < CNT_MAX) expCount++;
                end
            end
        end
        #1;
        checkOutput(tag);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 1'b0, DW'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          pt;
        logic          bad;
        logic          v;
        logic          clr;

        rst_n               = 1'b0;
        bus.valid_in        = 1'b0;
        bus.data_in         = '0;
        bus.received_parity = 1'b0;
        bus.parity_type     = PARITY_EVEN;
        bus.err_clear       = 1'b0;
        modelReset();
        #12;
        checkOutput("reset");
        rst_n = 1'b1;
        idle("post_reset_idle");

        $display("[TB] directed frames");
        applyStimulus("even_ok", 1'b1, 8'b10101010, 1'b0, PARITY_EVEN, 1'b0);
        checkBit("even_ok.data_const", 32'(bus.data_out), 32'h0000_00AA);
        checkBit("even_ok.perr_const", 32'(bus.parity_error), 32'd0);
        applyStimulus("even_bad", 1'b1, 8'b11111000, 1'b0, PARITY_EVEN, 1'b0);
        checkBit("even_bad.count_const", 32'(bus.err_count), 32'd1);
        applyStimulus("odd_ok", 1'b1, 8'b11001100, 1'b1, PARITY_ODD, 1'b0);
        checkBit("odd_ok.data_const", 32'(bus.data_out), 32'h0000_00CC);
        applyStimulus("odd_bad", 1'b1, 8'b11110000, 1'b0, PARITY_ODD, 1'b0);
        checkBit("odd_bad.count_const", 32'(bus.err_count), 32'd2);
        idle("hold_after_frames");
        applyStimulus("clear_only", 1'b0, 8'h00, 1'b0, PARITY_EVEN, 1'b1);

        $display("[TB] saturation");
        for (int i = 0; i < 300; i++) begin
            d = DW'($urandom);
            pt = 1'($urandom);
            applyStimulus("sat_run", 1'b1, d, parityFor(d, pt, 1'b1), pt, 1'b0);
        end
        checkBit("sat.count_const", 32'(bus.err_count), 32'd255);
        idle("sat_hold");
        d = 8'h5A;
        applyStimulus("clear_and_bad", 1'b1, d, parityFor(d, PARITY_EVEN, 1'b1), PARITY_EVEN, 1'b1);
        checkBit("clear_and_bad.count_const", 32'(bus.err_count), 32'd1);
        checkBit("clear_and_bad.sticky_const", 32'(bus.err_sticky), 32'd1);

        $display("[TB] async reset mid-stream");
        d = 8'h3C;
        applyStimulus("pre_reset", 1'b1, d, parityFor(d, PARITY_ODD, 1'b1), PARITY_ODD, 1'b0);
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h81;
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset");
        applyStimulus("in_reset", 1'b1, 8'h81, 1'b1, PARITY_EVEN, 1'b0);
        #2;
        rst_n = 1'b1;
        idle("after_release_1");
        idle("after_release_2");
        d = 8'h0F;
        applyStimulus("first_after_reset", 1'b1, d, parityFor(d, PARITY_EVEN, 1'b0), PARITY_EVEN, 1'b0);

        $display("[TB] randomized stream");
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(3) != 0);
            clr = ($urandom_range(15) == 0);
            d   = DW'($urandom);
            pt  = 1'($urandom);
            bad = 1'($urandom);
            applyStimulus("random", v, d, parityFor(d, pt, bad), pt, clr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
